// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time system ID checker: reads the sysid slave's ID word and build timestamp
// over Avalon-MM and reports match, mismatch or a stalled-slave timeout.
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1362456154,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timeout
);

  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned      CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      id_nxt, ts_nxt;
  logic             done_nxt, ok_nxt, to_nxt;
  logic             read_nxt, addr_nxt;

  // State, stall counter and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      captured_id <= '0;
      captured_ts <= '0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      timeout     <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      captured_id <= id_nxt;
      captured_ts <= ts_nxt;
      done        <= done_nxt;
      id_ok       <= ok_nxt;
      timeout     <= to_nxt;
      avm_read    <= read_nxt;
      avm_address <= addr_nxt;
      busy        <= read_nxt;
    end
  end

  // Next-state and next-output logic; bus strobes follow the state being entered.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = captured_id;
    ts_nxt    = captured_ts;
    done_nxt  = done;
    ok_nxt    = id_ok;
    to_nxt    = timeout;

    unique case (state)
      IDLE: begin
        if (AUTO_START || start) begin
          state_nxt = RD_ID;
          cnt_nxt   = '0;
        end
      end

      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          cnt_nxt = '0;
          if (state == RD_ID) begin
            id_nxt    = avm_readdata;
            state_nxt = RD_TS;
          end else begin
            ts_nxt    = avm_readdata;
            ok_nxt    = (captured_id == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end else if (TIMEOUT_EN && (cnt == CNT_MAX)) begin
          // Abort: the captured register of this read keeps its previous value.
          cnt_nxt   = '0;
          ok_nxt    = 1'b0;
          to_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (TIMEOUT_EN) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        if (start) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
          ok_nxt    = 1'b0;
          to_nxt    = 1'b0;
          state_nxt = RD_ID;
        end
      end

      default: state_nxt = IDLE;
    endcase

    read_nxt = (state_nxt == RD_ID) || (state_nxt == RD_TS);
    addr_nxt = (state_nxt == RD_TS);
  end

  // Status invariants the boot logic depends on.
  a_ok_to_exclusive: assert property (@(posedge clock) disable iff (!reset_n) !(id_ok && timeout));
  a_done_not_busy:   assert property (@(posedge clock) disable iff (!reset_n) !(done && busy));

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: bus transfers and results are queued as
// expectations by the stimulus and popped/compared by a negedge monitor.
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] TS     = 32'd1362456154;
  localparam logic [31:0] BAD_TS = 32'h1234_5678;
  localparam logic [31:0] BAD_ID = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        is_result;
    logic        addr;
    logic        ok;
    logic        tmo;
    logic [31:0] cid;
    logic [31:0] cts;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n, start_a, start_b;
  logic        addr_a, read_a, wait_a, busy_a, done_a, ok_a, to_a;
  logic        addr_b, read_b, wait_b, busy_b, done_b, ok_b, to_b;
  logic [31:0] rdata_a, cid_a, cts_a, d0_a, d1_a;
  logic [31:0] rdata_b, cid_b, cts_b, d0_b, d1_b;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          stall_cfg = 0;
  int          n;
  exp_t        sb[$];

  always #5 clock = ~clock;

  assign rdata_a = addr_a ? d1_a : d0_a;
  assign rdata_b = addr_b ? d1_b : d0_b;

  first_nios2_system_sysid_checker dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rdata_a), .avm_waitrequest(wait_a),
    .captured_id(cid_a), .captured_ts(cts_a),
    .busy(busy_a), .done(done_a), .id_ok(ok_a), .timeout(to_a)
  );

  first_nios2_system_sysid_checker #(
    .TIMEOUT_CYCLES(4), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_readdata(rdata_b), .avm_waitrequest(wait_b),
    .captured_id(cid_b), .captured_ts(cts_b),
    .busy(busy_b), .done(done_b), .id_ok(ok_b), .timeout(to_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t rd(input logic a);
    exp_t e = '0;
    e.addr = a;
    return e;
  endfunction

  function automatic exp_t res(input logic ok, input logic tmo, input logic [31:0] cid,
                               input logic [31:0] cts);
    exp_t e = '0;
    e.is_result = 1'b1;
    e.ok  = ok;
    e.tmo = tmo;
    e.cid = cid;
    e.cts = cts;
    return e;
  endfunction

  // Slave A: stalls each new request for stall_cfg cycles, then completes it.
  initial begin
    logic prev_read;
    int   left;
    prev_read = 1'b0;
    left      = 0;
    wait_a    = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (read_a && !(prev_read && wait_a)) left = stall_cfg;
      wait_a = read_a && (left > 0);
      if (wait_a) left--;
      prev_read = read_a;
    end
  end

  // Monitor for DUT A: completed transfers, new results and request stability under stall.
  logic done_prev  = 1'b0;
  logic stall_prev = 1'b0;
  logic addr_prev  = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && stall_prev) begin
      check("stall_read_held", 32'(read_a), 32'd1);
      check("stall_addr_held", 32'(addr_a), 32'(addr_prev));
    end
    stall_prev = reset_n && read_a && wait_a;
    addr_prev  = addr_a;
    if (reset_n && read_a && !wait_a) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_read: addr %0d with nothing expected at %0t", addr_a, $time);
      end else begin
        e = sb.pop_front();
        check("event_is_read", 32'd0, 32'(e.is_result));
        check("read_addr", 32'(addr_a), 32'(e.addr));
      end
    end
    if (reset_n && done_a && !done_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: done rose with nothing expected at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("event_is_result", 32'd1, 32'(e.is_result));
        check("res_id_ok", 32'(ok_a), 32'(e.ok));
        check("res_timeout", 32'(to_a), 32'(e.tmo));
        check("res_captured_id", cid_a, e.cid);
        check("res_captured_ts", cts_a, e.cts);
        check("res_not_busy", 32'(busy_a), 32'd0);
      end
    end
    done_prev = done_a;
  end

  task automatic pulse(input bit sel);
    @(posedge clock);
    #1;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Counts edges after the current one until done, bounded.
  task automatic count_to_done(input bit sel, output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      edges++;
      #1;
    end while (!(sel ? done_b : done_a) && edges < 300);
    check("done_reached", 32'(sel ? done_b : done_a), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    wait_b  = 1'b0;
    d0_a = 32'd0;
    d1_a = TS;
    d0_b = 32'd0;
    d1_b = TS;
    #12;
    check("rst_read_a", 32'(read_a), 32'd0);
    check("rst_addr_a", 32'(addr_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_ok_a", 32'(ok_a), 32'd0);
    check("rst_to_a", 32'(to_a), 32'd0);
    check("rst_cid_a", cid_a, 32'd0);
    check("rst_cts_a", cts_a, 32'd0);
    check("rst_read_b", 32'(read_b), 32'd0);

    // Auto-start with a matching slave.
    sb.push_back(rd(1'b0));
    sb.push_back(rd(1'b1));
    sb.push_back(res(1'b1, 1'b0, 32'd0, TS));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("t1_enter_read", 32'(read_a), 32'd1);
    check("t1_enter_addr", 32'(addr_a), 32'd0);
    check("t1_enter_busy", 32'(busy_a), 32'd1);
    count_to_done(1'b0, n);
    check("t1_latency", 32'(n), 32'd2);
    check("t1_id_ok", 32'(ok_a), 32'd1);
    check("t1_read_off", 32'(read_a), 32'd0);
    check("b_idle_busy", 32'(busy_b), 32'd0);
    check("b_idle_read", 32'(read_b), 32'd0);

    // Timestamp mismatch.
    d1_a = BAD_TS;
    sb.push_back(rd(1'b0));
    sb.push_back(rd(1'b1));
    sb.push_back(res(1'b0, 1'b0, 32'd0, BAD_TS));
    pulse(1'b0);
    check("t2_done_cleared", 32'(done_a), 32'd0);
    count_to_done(1'b0, n);
    check("t2_latency", 32'(n), 32'd2);

    // Three stall cycles on each read.
    d1_a = TS;
    stall_cfg = 3;
    sb.push_back(rd(1'b0));
    sb.push_back(rd(1'b1));
    sb.push_back(res(1'b1, 1'b0, 32'd0, TS));
    pulse(1'b0);
    count_to_done(1'b0, n);
    check("t3_latency", 32'(n), 32'd8);
    check("t3_id_ok", 32'(ok_a), 32'd1);

    // Rerun with mismatch; a start while busy must be ignored.
    stall_cfg = 0;
    d1_a = BAD_TS;
    sb.push_back(rd(1'b0));
    sb.push_back(rd(1'b1));
    sb.push_back(res(1'b0, 1'b0, 32'd0, BAD_TS));
    pulse(1'b0);
    check("t5_busy", 32'(busy_a), 32'd1);
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    count_to_done(1'b0, n);
    repeat (5) @(posedge clock);
    #1;
    check("t5_still_done", 32'(done_a), 32'd1);
    check("t5_no_rerun", 32'(read_a), 32'd0);

    // Instance B: start-driven check, then a stuck slave and timeout.
    pulse(1'b1);
    count_to_done(1'b1, n);
    check("t4_pre_latency", 32'(n), 32'd2);
    check("t4_pre_ok", 32'(ok_b), 32'd1);
    d0_b   = BAD_ID;
    wait_b = 1'b1;
    pulse(1'b1);
    count_to_done(1'b1, n);
    // Four stalled edges are tolerated; the fifth with the counter at 4 aborts.
    check("t4_abort_edge", 32'(n), 32'd5);
    check("t4_read_off", 32'(read_b), 32'd0);
    check("t4_busy_off", 32'(busy_b), 32'd0);
    check("t4_timeout", 32'(to_b), 32'd1);
    check("t4_id_ok", 32'(ok_b), 32'd0);
    check("t4_cid_kept", cid_b, 32'd0);
    wait_b = 1'b0;
    pulse(1'b1);
    check("t4_to_cleared", 32'(to_b), 32'd0);
    count_to_done(1'b1, n);
    check("t4_rerun_ok", 32'(ok_b), 32'd0);
    check("t4_rerun_to", 32'(to_b), 32'd0);
    check("t4_rerun_cid", cid_b, BAD_ID);

    // Reset while stalled in the timestamp read.
    d1_a = TS;
    stall_cfg = 10;
    sb.push_back(rd(1'b0));
    pulse(1'b0);
    repeat (14) @(posedge clock);
    #1;
    check("t6_in_rd_ts", 32'(addr_a), 32'd1);
    check("t6_reading", 32'(read_a), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_read", 32'(read_a), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_addr", 32'(addr_a), 32'd0);
    check("t6_rst_cts", cts_a, 32'd0);
    check("t6_rst_done_b", 32'(done_b), 32'd0);
    check("t6_rst_cid_b", cid_b, 32'd0);
    stall_cfg = 0;
    sb.push_back(rd(1'b0));
    sb.push_back(rd(1'b1));
    sb.push_back(res(1'b1, 1'b0, 32'd0, TS));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("t6_restart_busy", 32'(busy_a), 32'd1);
    count_to_done(1'b0, n);
    check("t6_latency", 32'(n), 32'd2);
    check("t6_id_ok", 32'(ok_a), 32'd1);

    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/first_nios2_system_sysid_checker.md
Name: first_nios2_system_sysid_checker

Overview:
- Avalon-MM master that sits directly upstream of the system ID slave and consumes its readdata.
- After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp) from the slave.
- It compares both words against build-time expected values and reports pass, mismatch or timeout.
- Its status outputs feed the boot/status logic, which holds the processor or flags a wrong bitstream/software pairing.

Parameters:
- EXPECTED_ID, default 0: value required at slave address 0.
- EXPECTED_TS, default 1362456154: value required at slave address 1.
- TIMEOUT_CYCLES, default 255: maximum waitrequest-stalled cycles per read. 0 disables the timeout.
- AUTO_START, default 1: 1 = begin a check automatically on the first clock after reset release.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to run (or re-run) a check.
- avm_address  output  1  word address to the ID slave.
- avm_read  output  1  read strobe.
- avm_readdata  input  32  slave read data; zero read latency.
- avm_waitrequest  input  1  slave stall; the transfer completes on an edge where avm_read=1 and avm_waitrequest=0.
- captured_id  output  32  last value read from address 0.
- captured_ts  output  32  last value read from address 1.
- busy  output  1  check in progress.
- done  output  1  check finished; held until the next start.
- id_ok  output  1  both words matched; valid only while done=1.
- timeout  output  1  a read exceeded TIMEOUT_CYCLES; valid only while done=1.

Behaviour:
- Reset: one clock, asynchronous active-low reset. While reset_n=0, all outputs are 0, the FSM is in IDLE and the timeout counter is 0. Assertion clears everything immediately, including avm_read in mid-transfer; no partial result is retained.
- States: IDLE, RD_ID, RD_TS, DONE. All outputs are registered.
- IDLE:
  - With AUTO_START=1, go to RD_ID on the first rising edge with reset_n=1.
  - Otherwise go to RD_ID on an edge with start=1.
- RD_ID: avm_read=1, avm_address=0, busy=1.
  - On an edge with avm_waitrequest=0: captured_id <= avm_readdata; go to RD_TS; counter <= 0.
- RD_TS: avm_read=1, avm_address=1, busy=1.
  - On an edge with avm_waitrequest=0: captured_ts <= avm_readdata; id_ok <= (captured_id==EXPECTED_ID) && (avm_readdata==EXPECTED_TS); done <= 1; go to DONE.
- avm_read and avm_address stay stable while avm_waitrequest=1.
- Read strobe: avm_read deasserts on the same edge the second transfer completes. No idle cycle is inserted between the two reads.
- Latency: with waitrequest held low, the edge entering RD_ID is followed by RD_TS one edge later and done=1 two edges later.
- Timeout:
  - The counter (width clog2(TIMEOUT_CYCLES+1)) increments on each edge in RD_ID/RD_TS with avm_waitrequest=1.
  - When the counter equals TIMEOUT_CYCLES and waitrequest is still 1 on that edge: go to DONE; timeout<=1, done<=1, id_ok<=0, avm_read<=0.
  - The captured register of the aborted read keeps its old value.
- DONE: busy=0; done, id_ok and timeout held.
  - start=1 clears done, id_ok and timeout on that edge and enters RD_ID.
- start while busy=1 is ignored and not queued. start in IDLE with AUTO_START=1 has no extra effect.
- Invariants: id_ok and timeout are never both 1; done=1 implies busy=0.
- Comparisons are full 32-bit equality. No arithmetic on the data path.

Test Plan:
1. Matching slave (addr0=0, addr1=1362456154, waitrequest=0), AUTO_START=1 -> reads at addr 0 then 1 on consecutive cycles; done=1 and id_ok=1 two edges after entering RD_ID; captured_ts=1362456154.
2. Slave returns 0x12345678 at addr1 -> done=1, id_ok=0, timeout=0, captured_ts=0x12345678.
3. waitrequest high for 3 cycles on each read, TIMEOUT_CYCLES=255 -> avm_read/avm_address stable throughout stalls; done after 8 edges; id_ok=1.
4. waitrequest stuck high, TIMEOUT_CYCLES=4 -> after 4 stalled edges in RD_ID: avm_read=0, done=1, timeout=1, id_ok=0, captured_id unchanged.
5. In DONE, change addr1 data to a mismatch and pulse start -> done clears for one edge and the check reruns ending id_ok=0; a second start pulse issued while busy is ignored (exactly two reads observed).
6. reset_n low while stalled in RD_TS -> avm_read, busy, done, captured_* go to 0 without a clock edge; after release (AUTO_START=1) a full check completes normally.
